dcache_axi_bridge: RTL and testbench
====================================

// Module: dcache_axi_bridge
// PURPOSE
//  Line-granular AXI4 master behind the data cache; performs 8-beat INCR bursts for refills and write-backs.
//  Accepts one cache-line request at a time (write-back or refill), runs the AXI burst and returns a one-cycle grant.
//  Holds the refill line stable after the grant so the cache can write it into its RAMs in the following cycle.
//  Fixed AXI fields are tied off at top level: ID=0, SIZE=3'b010, BURST=2'b01, WSTRB=4'hF.
// PARAMETERS
//  LINE_WORDS  8   32-bit words per line; burst length = LINE_WORDS; ARLEN/AWLEN = LINE_WORDS-1
//  CNT_W       3   beat counter width, equal to log2(LINE_WORDS)
// PORTS
//  clk            in   1    clock, all state changes on posedge
//  rst            in   1    synchronous, active-high reset
//  cache_addr     in   32   line address from cache; bits [4:0] ignored (forced 0 on AXI)
//  cache_rd_req   in   1    refill request, level, held until cache_gnt
//  cache_wr_req   in   1    write-back request, level, held until cache_gnt
//  cache_wr_data  in   256  write-back line, word i = bits [32i+31:32i]
//  cache_rd_data  out  256  refill line, same word order, registered
//  cache_gnt      out  1    one-cycle pulse: transaction complete
//  araddr         out  32   read burst address
//  arlen          out  8    constant LINE_WORDS-1
//  arvalid        out  1    read address valid
//  arready        in   1    read address ready
//  rdata          in   32   read beat data
//  rlast          in   1    last read beat
//  rvalid         in   1    read beat valid
//  rready         out  1    read beat ready
//  awaddr         out  32   write burst address
//  awlen          out  8    constant LINE_WORDS-1
//  awvalid        out  1    write address valid
//  awready        in   1    write address ready
//  wdata          out  32   write beat data
//  wlast          out  1    last write beat
//  wvalid         out  1    write beat valid
//  wready         in   1    write beat ready
//  bvalid         in   1    write response valid
//  bready         out  1    write response ready
// BEHAVIOUR
//  States: IDLE, AR, R, AW, W, B, GNT. Reset: state=IDLE, every valid/ready=0, cache_gnt=0, cache_rd_data=0, counter=0.
//  IDLE: wr_req -> AW (priority over rd_req); else rd_req -> AR. On leaving IDLE, latch {cache_addr[31:5],5'b0}.
//    On a write, also latch cache_wr_data into wbuf. Requests are sampled only in IDLE.
//  AR: arvalid=1, araddr=latched addr; stays until arready, then -> R with counter=0.
//  R: rready=1; each rvalid beat stores rdata into cache_rd_data word[counter] and increments counter.
//    A beat with rlast -> GNT (rlast is authoritative). Counter wraps mod LINE_WORDS.
//  AW: awvalid=1; stays until awready, then -> W with counter=0.
//  W: wvalid=1, wdata=wbuf[counter], wlast=(counter==LINE_WORDS-1). Counter advances only on wvalid&&wready.
//    The last beat handshake -> B.
//  B: bready=1; bvalid -> GNT. bresp is not checked.
//  GNT: cache_gnt=1 for exactly one cycle, then -> IDLE. The cache still holds its req in this cycle; it is ignored.
//  AXI outputs are held stable while valid && !ready. cache_rd_data changes only on R beats.
//    It holds the last line until the next refill's first beat.
//  Min latency (req seen cycle 0, all slaves ready):
//    read: arvalid cycle 1, beats 2..9, gnt cycle 10.
//    write: awvalid cycle 1, beats 2..9, bready cycle 10, gnt cycle 11.
//  Dirty miss: write-back gnt, then refill req accepted the following cycle (back-to-back).
//  Reset mid-burst: immediately IDLE, all valids dropped. The interconnect shares rst.
// TESTING
//  Refill at 0x1000_0024, slave returns 0xA0..0xA7 with no stalls -> araddr=0x1000_0020, arlen=7, gnt at cycle 10.
//    cache_rd_data word i=0xA0+i; data is held after gnt.
//  Write-back at 0x2000_0040, wbuf words 0xB0..0xB7, wready toggled 1/0 -> wdata order 0xB0..0xB7.
//    wlast on 0xB7 only; gnt one cycle after bvalid.
//  wr_req and rd_req high together at different addrs -> AW burst first, gnt.
//    With wr_req dropped, the next-cycle rd_req runs the AR burst.
//  arready delayed 5 cycles, rvalid gaps -> arvalid/araddr stable throughout; exactly 8 words captured; single gnt pulse.
//  rst asserted at beat 4 of a read -> next cycle all valid/ready=0, state IDLE.
//    A fresh read then completes normally.
//  Req held high through the gnt cycle -> no duplicate transaction is started from that cycle.

Source files
------------

// File: rtl/dcache_axi_bridge.sv
// Line-granular AXI4 master for the data cache: one refill or write-back at a time,
// each run as a single INCR burst of LINE_WORDS beats and finished with a one-cycle grant.
module dcache_axi_bridge #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                cache_addr,
  input  logic                       cache_rd_req,
  input  logic                       cache_wr_req,
  input  logic [LINE_WORDS*32-1:0]   cache_wr_data,
  output logic [LINE_WORDS*32-1:0]   cache_rd_data,
  output logic                       cache_gnt,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFS_W  = CNT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_GNT
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]                   cnt;
  logic [CNT_W-1:0]                   cnt_next;
  logic [31:0]                        addr_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0]  wbuf;
  logic [LINE_WORDS-1:0][WORD_W-1:0]  rd_line;

  logic                               r_fire;
  logic                               w_fire;
  logic                               aw_fire;
  logic                               ar_fire;
  logic                               b_fire;

  logic                               arvalid_d;
  logic                               rready_d;
  logic                               awvalid_d;
  logic                               wvalid_d;
  logic                               wlast_d;
  logic [WORD_W-1:0]                  wdata_d;
  logic                               bready_d;
  logic                               gnt_d;

  // Byte offset within the line is never driven onto the bus.
  logic                               unused_addr_bits;
  assign unused_addr_bits = ^cache_addr[OFS_W-1:0];

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid  && rready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid  && wready;
  assign b_fire  = bvalid  && bready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and beat counter; rlast alone terminates a read burst
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (cache_wr_req) begin
          state_next = S_AW;
        end else if (cache_rd_req) begin
          state_next = S_AR;
        end
      end
      S_AR: begin
        if (ar_fire) begin
          state_next = S_R;
          cnt_next   = '0;
        end
      end
      S_R: begin
        if (r_fire) begin
          cnt_next = cnt + 1'b1;
          if (rlast) begin
            state_next = S_GNT;
          end
        end
      end
      S_AW: begin
        if (aw_fire) begin
          state_next = S_W;
          cnt_next   = '0;
        end
      end
      S_W: begin
        if (w_fire) begin
          cnt_next = cnt + 1'b1;
          if (wlast) begin
            state_next = S_B;
          end
        end
      end
      S_B: begin
        if (b_fire) begin
          state_next = S_GNT;
        end
      end
      S_GNT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Next values of the registered AXI/cache outputs, decoded from the upcoming state
  always_comb begin
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    wlast_d   = 1'b0;
    wdata_d   = '0;
    bready_d  = 1'b0;
    gnt_d     = 1'b0;
    case (state_next)
      S_AR:  arvalid_d = 1'b1;
      S_R:   rready_d  = 1'b1;
      S_AW:  awvalid_d = 1'b1;
      S_W: begin
        wvalid_d = 1'b1;
        wdata_d  = wbuf[cnt_next];
        wlast_d  = (cnt_next == CNT_W'(LINE_WORDS - 1));
      end
      S_B:   bready_d  = 1'b1;
      S_GNT: gnt_d     = 1'b1;
      default: begin
        gnt_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      wdata     <= '0;
      bready    <= 1'b0;
      cache_gnt <= 1'b0;
    end else begin
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      wlast     <= wlast_d;
      wdata     <= wdata_d;
      bready    <= bready_d;
      cache_gnt <= gnt_d;
    end
  end

  // Request latch on leaving IDLE, beat counter and refill line capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wbuf    <= '0;
      rd_line <= '0;
    end else begin
      cnt <= cnt_next;
      if ((state == S_IDLE) && (state_next != S_IDLE)) begin
        addr_q <= {cache_addr[31:OFS_W], OFS_W'(0)};
        if (cache_wr_req) begin
          wbuf <= cache_wr_data;
        end
      end
      if ((state == S_R) && r_fire) begin
        rd_line[cnt] <= rdata;
      end
    end
  end

  assign cache_rd_data = rd_line;
  assign araddr        = addr_q;
  assign awaddr        = addr_q;
  assign arlen         = 8'(LINE_WORDS - 1);
  assign awlen         = 8'(LINE_WORDS - 1);

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Scoreboard bench for dcache_axi_bridge: a reactive AXI slave, directed cache requests,
// and a negedge monitor that checks every address, write beat and grant against queued expectations.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cache_addr;
  logic         cache_rd_req;
  logic         cache_wr_req;
  logic [255:0] cache_wr_data;
  logic [255:0] cache_rd_data;
  logic         cache_gnt;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  dcache_axi_bridge #(.LINE_WORDS(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cache_addr(cache_addr), .cache_rd_req(cache_rd_req), .cache_wr_req(cache_wr_req),
    .cache_wr_data(cache_wr_data), .cache_rd_data(cache_rd_data), .cache_gnt(cache_gnt),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
    int           cyc;
  } gnt_t;

  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];
  gnt_t        exp_gnt_q[$];

  // Slave configuration for the current transaction
  int           ar_delay = 0;
  bit           r_gap    = 1'b0;
  bit           w_toggle = 1'b0;
  int           b_delay  = 0;
  logic [255:0] rd_line_cfg = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Reactive AXI slave, driven 2 time units after each rising edge
  initial begin
    bit arv_s, rr_s, awv_s, wv_s, wl_s, br_s;
    bit r_active, w_active, b_active, r_fire, w_fire;
    int ar_cnt, r_beat, b_cnt;
    arv_s = 0; rr_s = 0; awv_s = 0; wv_s = 0; wl_s = 0; br_s = 0;
    r_active = 0; w_active = 0; b_active = 0; ar_cnt = 0; r_beat = 0; b_cnt = 0;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        r_active = 0; w_active = 0; b_active = 0; ar_cnt = 0;
      end else begin
        if (arready && arv_s) begin
          arready = 0; ar_cnt = 0; r_active = 1; r_beat = 0;
        end else if (arvalid && !r_active) begin
          if (ar_cnt >= ar_delay) arready = 1;
          else ar_cnt++;
        end
        r_fire = rvalid && rr_s;
        if (r_fire) r_beat++;
        if (r_active) begin
          if (r_beat >= 8) begin
            r_active = 0; rvalid = 0; rlast = 0;
          end else if (r_gap && r_fire) begin
            rvalid = 0; rlast = 0;
          end else if (!rvalid || r_fire) begin
            rvalid = 1; rdata = rd_line_cfg[r_beat*32 +: 32]; rlast = (r_beat == 7);
          end
        end
        if (awready && awv_s) begin
          awready = 0; w_active = 1;
        end else if (awvalid && !w_active) begin
          awready = 1;
        end
        w_fire = wready && wv_s;
        if (w_fire && wl_s) begin
          w_active = 0; b_active = 1; b_cnt = 0;
        end
        if (w_active) wready = w_toggle ? !wready : 1'b1;
        else wready = 0;
        if (bvalid && br_s) begin
          bvalid = 0; b_active = 0;
        end else if (b_active) begin
          if (b_cnt >= b_delay) bvalid = 1;
          else b_cnt++;
        end
      end
      arv_s = arvalid; rr_s = rready; awv_s = awvalid; wv_s = wvalid; wl_s = wlast; br_s = bready;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues
  int   last_r_cyc = -100;
  int   last_b_cyc = -100;
  gnt_t g;
  logic [32:0] we;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (arvalid) begin
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else begin
          check("araddr", 256'(araddr), 256'(exp_ar_q[0]));
          if (arready) begin
            check("arlen", 256'(arlen), 256'(7));
            void'(exp_ar_q.pop_front());
          end
        end
      end
      if (awvalid) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          check("awaddr", 256'(awaddr), 256'(exp_aw_q[0]));
          if (awready) begin
            check("awlen", 256'(awlen), 256'(7));
            void'(exp_aw_q.pop_front());
          end
        end
      end
      if (wvalid) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else begin
          we = exp_w_q[0];
          check("wdata", 256'(wdata), 256'(we[31:0]));
          check("wlast", 256'(wlast), 256'(we[32]));
          if (wready) void'(exp_w_q.pop_front());
        end
      end
      if (rvalid && rready && rlast) last_r_cyc = cyc;
      if (bvalid && bready) last_b_cyc = cyc;
      if (cache_gnt) begin
        if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected");
        else begin
          g = exp_gnt_q.pop_front();
          if (g.is_rd) begin
            check("rd_line", cache_rd_data, g.line);
            check("gnt_after_rlast", 256'(cyc), 256'(last_r_cyc + 1));
          end else begin
            check("gnt_after_b", 256'(cyc), 256'(last_b_cyc + 1));
          end
          if (g.cyc >= 0) check("gnt_cycle", 256'(cyc), 256'(g.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (cache_gnt !== 1'b1 && n < 300);
    if (cache_gnt !== 1'b1) fail_now({name, "_gnt_timeout"});
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] base, input bit timed);
    gnt_t e;
    rd_line_cfg = mk_line(base);
    exp_ar_q.push_back({addr[31:5], 5'b0});
    e.is_rd = 1'b1;
    e.line  = mk_line(base);
    e.cyc   = timed ? cyc + 10 : -1;
    exp_gnt_q.push_back(e);
    cache_addr   = addr;
    cache_rd_req = 1'b1;
    wait_gnt("read");
    tick();
    cache_rd_req = 1'b0;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] base, input int gcyc);
    gnt_t e;
    exp_aw_q.push_back({addr[31:5], 5'b0});
    for (int i = 0; i < 8; i++) exp_w_q.push_back({(i == 7), base + 32'(i)});
    e.is_rd = 1'b0;
    e.line  = '0;
    e.cyc   = gcyc;
    exp_gnt_q.push_back(e);
  endtask

  initial begin
    gnt_t e;
    int   c;
    rst = 1'b1;
    cache_addr = '0; cache_rd_req = 0; cache_wr_req = 0; cache_wr_data = '0;
    repeat (3) tick();
    check("rst_arvalid", 256'(arvalid), 256'(0));
    check("rst_rready", 256'(rready), 256'(0));
    check("rst_awvalid", 256'(awvalid), 256'(0));
    check("rst_wvalid", 256'(wvalid), 256'(0));
    check("rst_bready", 256'(bready), 256'(0));
    check("rst_gnt", 256'(cache_gnt), 256'(0));
    check("rst_rd_data", cache_rd_data, 256'(0));
    rst = 1'b0;
    tick();

    // Refill with no stalls, then confirm the line is held
    do_read(32'h1000_0024, 32'hA0, 1'b1);
    repeat (3) tick();
    check("rd_hold_after_gnt", cache_rd_data, mk_line(32'hA0));

    // Write-back with wready toggling
    w_toggle = 1'b1;
    cache_wr_data = mk_line(32'hB0);
    push_write(32'h2000_0040, 32'hB0, -1);
    cache_addr = 32'h2000_0040;
    cache_wr_req = 1'b1;
    wait_gnt("write");
    tick();
    cache_wr_req = 1'b0;
    check("rd_hold_over_write", cache_rd_data, mk_line(32'hA0));
    w_toggle = 1'b0;
    tick();

    // Dirty miss: both requests, write first, refill accepted right after
    c = cyc;
    cache_wr_data = mk_line(32'hC0);
    push_write(32'h3000_0000, 32'hC0, c + 11);
    rd_line_cfg = mk_line(32'hD0);
    exp_ar_q.push_back(32'h4000_0060);
    e.is_rd = 1'b1; e.line = mk_line(32'hD0); e.cyc = c + 22;
    exp_gnt_q.push_back(e);
    cache_addr = 32'h3000_0000;
    cache_wr_req = 1'b1;
    cache_rd_req = 1'b1;
    wait_gnt("dirty_wb");
    tick();
    cache_wr_req = 1'b0;
    cache_addr = 32'h4000_007C;
    wait_gnt("dirty_refill");
    tick();
    cache_rd_req = 1'b0;
    tick();

    // Delayed arready and gaps between read beats
    ar_delay = 5;
    r_gap = 1'b1;
    do_read(32'h5000_0100, 32'hE0, 1'b0);
    ar_delay = 0;
    r_gap = 1'b0;
    tick();

    // Reset during beat 4 of a read, then a fresh read
    rd_line_cfg = mk_line(32'hF0);
    exp_ar_q.push_back(32'h6000_0000);
    cache_addr = 32'h6000_0000;
    cache_rd_req = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    cache_rd_req = 1'b0;
    tick();
    check("mid_rst_arvalid", 256'(arvalid), 256'(0));
    check("mid_rst_rready", 256'(rready), 256'(0));
    check("mid_rst_awvalid", 256'(awvalid), 256'(0));
    check("mid_rst_wvalid", 256'(wvalid), 256'(0));
    check("mid_rst_bready", 256'(bready), 256'(0));
    check("mid_rst_gnt", 256'(cache_gnt), 256'(0));
    check("mid_rst_rd_data", cache_rd_data, 256'(0));
    exp_ar_q.delete();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_gnt_q.delete();
    rst = 1'b0;
    tick();
    do_read(32'h6000_0020, 32'h60, 1'b1);

    repeat (6) tick();
    check("left_ar", 256'(exp_ar_q.size()), 256'(0));
    check("left_aw", 256'(exp_aw_q.size()), 256'(0));
    check("left_w", 256'(exp_w_q.size()), 256'(0));
    check("left_gnt", 256'(exp_gnt_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
